// File: rtl/imem_loader_if.sv
// Byte-stream handshake bundle feeding the instruction-memory loader.
// The source drives data/valid; the loader answers with ready.
interface imem_loader_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction memory filled at run time from a length-prefixed byte stream.
// Optional trailing checksum byte and error state are compiled in with IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// S_IDLE | no load active, CPU runs from memory
// S_LEN  | waiting for the length byte
// S_LOAD | writing payload bytes at r_ptr
// S_CHK  | waiting for the checksum byte (checksum build only)
// S_ERR  | checksum mismatch, CPU held until restart (checksum build only)
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load_start,
   imem_loader_if.slave      io_stream,
   input  logic [ADDR_W-1:0] i_read_address,
   output logic [7:0]        o_instruction,
   output logic              o_cpu_hold,
   output logic              o_load_done,
   output logic              o_load_error
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_LEN   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] REMAIN_ONE = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_LOAD = 3'd2
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      S_CHK  = 3'd3,
      S_ERR  = 3'd4
`endif
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_remain;
   logic              r_load_done;
   logic              w_done;
   logic              w_accepting;
   logic              w_ready;
   logic              w_xfer;
   logic              w_wr;
   logic [ADDR_W:0]   w_len;
   logic [7:0]        r_mem [DEPTH];

   // Length byte is zero-extended or truncated to ADDR_W+1 bits.
   generate
      if (ADDR_W + 1 > 8) begin : g_len_ext
         assign w_len = {{(ADDR_W + 1 - 8){1'b0}}, io_stream.data};
      end else if (ADDR_W + 1 == 8) begin : g_len_eq
         assign w_len = io_stream.data;
      end else begin : g_len_trunc
         assign w_len = io_stream.data[ADDR_W:0];
      end
   endgenerate

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_sum;
   logic [7:0] w_sum_next;

   assign w_sum_next  = r_sum + io_stream.data;
   assign w_accepting = (r_state == S_LEN) || (r_state == S_LOAD) || (r_state == S_CHK);
`else
   assign w_accepting = (r_state == S_LEN) || (r_state == S_LOAD);
`endif

   // A restart pulse masks ready so the coincident byte is never consumed.
   assign w_ready         = w_accepting & ~i_load_start;
   assign io_stream.ready = w_ready;
   assign w_xfer          = io_stream.valid & w_ready;
   assign w_wr            = w_xfer && (r_state == S_LOAD);

   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      if (i_load_start) begin
         w_next = S_LEN;
      end else begin
         case (r_state)
            S_LEN: begin
               if (w_xfer) begin
                  w_next = S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_xfer && (r_remain == REMAIN_ONE)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  w_next = S_CHK;
`else
                  w_next = S_IDLE;
                  w_done = 1'b1;
`endif
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (w_xfer) begin
                  if (w_sum_next == 8'h00) begin
                     w_next = S_IDLE;
                     w_done = 1'b1;
                  end else begin
                     w_next = S_ERR;
                  end
               end
            end
            S_ERR: begin
               w_next = S_ERR;
            end
`endif
            default: begin
               w_next = r_state;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_load_done <= 1'b0;
         r_ptr       <= '0;
         r_remain    <= '0;
      end else begin
         r_state     <= w_next;
         r_load_done <= w_done;
         if (i_load_start) begin
            r_ptr    <= '0;
            r_remain <= '0;
         end else if (w_xfer) begin
            if (r_state == S_LEN) begin
               r_remain <= (w_len == '0) ? FULL_LEN : w_len;
            end else if (r_state == S_LOAD) begin
               r_ptr    <= r_ptr + ADDR_W'(1);
               r_remain <= r_remain - REMAIN_ONE;
            end
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Sum covers the length byte and payload; the checksum byte is folded in at S_CHK.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sum <= 8'h00;
      end else if (i_load_start) begin
         r_sum <= 8'h00;
      end else if (w_xfer && ((r_state == S_LEN) || (r_state == S_LOAD))) begin
         r_sum <= w_sum_next;
      end
   end

   assign o_load_error = (r_state == S_ERR);
`else
   assign o_load_error = 1'b0;
`endif

   // Reset clears every byte so an unloaded memory decodes as a harmless instruction.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else if (w_wr) begin
         r_mem[r_ptr] <= io_stream.data;
      end
   end

   assign o_instruction = r_mem[i_read_address];
   assign o_cpu_hold    = (r_state != S_IDLE);
   assign o_load_done   = r_load_done;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed test-plan loads plus randomized loads, all checked
// every cycle against a byte-level model of the loader. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
   logic       clk;
   logic       rst;
   logic       load_start;
   logic [7:0] rd_addr;
   logic [7:0] instr;
   logic       hold;
   logic       done;
   logic       err;

   imem_loader_if stream_if ();

   imem_loader #(.ADDR_W(8)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_load_start   (load_start),
      .io_stream      (stream_if),
      .i_read_address (rd_addr),
      .o_instruction  (instr),
      .o_cpu_hold     (hold),
      .o_load_done    (done),
      .o_load_error   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done_seen = 0;
   bit cmp_en = 1'b0;
   bit rnd_rd = 1'b0;

   // Model: what the loader has been told so far, in byte-stream terms.
   logic [7:0] m_mem [256];
   bit         m_busy;
   bit         m_have_len;
   bit         m_failed;
   bit         m_done;
   int         m_left;
   int         m_ptr;
   int         m_sum;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
         m_busy = 0; m_have_len = 0; m_failed = 0; m_done = 0;
         m_left = 0; m_ptr = 0; m_sum = 0;
      end else begin
         m_done = 0;
         if (load_start) begin
            m_busy = 1; m_have_len = 0; m_failed = 0;
            m_left = 0; m_ptr = 0; m_sum = 0;
         end else if (stream_if.valid && m_busy && !m_failed) begin
            m_sum = (m_sum + int'(stream_if.data)) % 256;
            if (!m_have_len) begin
               m_have_len = 1;
               m_left = (stream_if.data == 8'h00) ? 256 : int'(stream_if.data);
            end else if (m_left > 0) begin
               m_mem[m_ptr % 256] = stream_if.data;
               m_ptr++;
               m_left--;
`ifndef IMEM_LOADER_CHECKSUM_EN
               if (m_left == 0) begin
                  m_busy = 0;
                  m_done = 1;
               end
`endif
            end else begin
               if (m_sum == 0) begin
                  m_busy = 0;
                  m_done = 1;
               end else begin
                  m_failed = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("in_ready",    8'(stream_if.ready), 8'(m_busy && !m_failed && !load_start));
         check("cpu_hold",    8'(hold), 8'(m_busy));
         check("load_done",   8'(done), 8'(m_done));
         check("load_error",  8'(err),  8'(m_failed));
         check("instruction", instr, m_mem[rd_addr]);
         if (done) n_done_seen++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      if (rnd_rd) rd_addr = 8'($urandom_range(0, 255));
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // mode 0: back-to-back, 1: one idle cycle before each byte, 2: random 0..3 idle cycles
   task automatic send_byte(input logic [7:0] b, input int mode);
      int  g;
      bit  acc;
      bit  ok;
      g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (g > 0) begin
         stream_if.valid = 1'b0;
         repeat (g) tick();
      end
      stream_if.data  = b;
      stream_if.valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         acc = stream_if.ready;
         @(posedge clk);
         #2;
         if (rnd_rd) rd_addr = 8'($urandom_range(0, 255));
         if (acc) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: actual no_accept required accept of %0h", b);
      end
   endtask

   task automatic do_load(input logic [7:0] len_b, input logic [7:0] pay[$],
                          input int mode, input bit bad_chk);
      logic [7:0] s;
      pulse_start();
      send_byte(len_b, mode);
      s = len_b;
      foreach (pay[i]) begin
         send_byte(pay[i], mode);
         s = s + pay[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (8'h01 - s) : (8'h00 - s), mode);
`else
      if (bad_chk) s = s + 8'h00;
`endif
      stream_if.valid = 1'b0;
      tick();
   endtask

   task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string nm);
      rd_addr = a;
      #1;
      check(nm, instr, exp);
   endtask

   task automatic junk(input int n);
      for (int k = 0; k < n; k++) begin
         stream_if.valid = 1'($urandom_range(0, 1));
         stream_if.data  = 8'($urandom_range(0, 255));
         tick();
      end
      stream_if.valid = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      int base;
      int n;

      rst = 1'b1; load_start = 1'b0; rd_addr = 8'h00;
      stream_if.valid = 1'b0; stream_if.data = 8'h00;
      tick();
      cmp_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_hold", 8'(hold), 8'h00);
      check("rst_ready", 8'(stream_if.ready), 8'h00);
      check("rst_done", 8'(done), 8'h00);
      check("rst_error", 8'(err), 8'h00);
      for (int a = 0; a < 256; a++) peek(8'(a), 8'h00, "rst_sweep");
      junk(6);

      // Basic load, valid held high
      base = n_done_seen;
`ifdef IMEM_LOADER_CHECKSUM_EN
      q = '{8'h51, 8'h59};
      pulse_start();
      send_byte(8'h02, 0); send_byte(8'h51, 0); send_byte(8'h59, 0); send_byte(8'h54, 0);
      stream_if.valid = 1'b0;
      tick();
      check("chk_good_err", 8'(err), 8'h00);
      check("chk_good_hold", 8'(hold), 8'h00);
      check("chk_good_done", 8'(n_done_seen - base), 8'd1);
      peek(8'd0, 8'h51, "chk_good_m0");
      peek(8'd1, 8'h59, "chk_good_m1");
      peek(8'd2, 8'h00, "chk_good_m2");
`else
      q = '{8'h51, 8'h59, 8'h1B};
      do_load(8'h03, q, 0, 1'b0);
      check("basic_done", 8'(n_done_seen - base), 8'd1);
      check("basic_hold", 8'(hold), 8'h00);
      peek(8'd0, 8'h51, "basic_m0");
      peek(8'd1, 8'h59, "basic_m1");
      peek(8'd2, 8'h1B, "basic_m2");
      peek(8'd3, 8'h00, "basic_m3");
`endif

      // Same stream with valid toggling every other cycle
      base = n_done_seen;
      do_load(8'(q.size()), q, 1, 1'b0);
      check("gap_done", 8'(n_done_seen - base), 8'd1);
      peek(8'd0, 8'h51, "gap_m0");
      peek(8'd1, 8'h59, "gap_m1");

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad checksum holds the CPU until restart
      base = n_done_seen;
      pulse_start();
      send_byte(8'h02, 0); send_byte(8'h51, 0); send_byte(8'h59, 0); send_byte(8'h55, 0);
      stream_if.valid = 1'b0;
      tick();
      junk(5);
      check("chk_bad_err", 8'(err), 8'h01);
      check("chk_bad_hold", 8'(hold), 8'h01);
      check("chk_bad_done", 8'(n_done_seen - base), 8'd0);
      pulse_start();
      check("chk_restart_err", 8'(err), 8'h00);
`endif

      // Full-depth load with N = 0
      base = n_done_seen;
      q.delete();
      for (int i = 0; i < 256; i++) q.push_back(8'(i));
      do_load(8'h00, q, 0, 1'b0);
      check("full_done", 8'(n_done_seen - base), 8'd1);
      stream_if.data = 8'hAA; stream_if.valid = 1'b1;
      #1;
      check("full_257_ready", 8'(stream_if.ready), 8'h00);
      tick(); tick();
      stream_if.valid = 1'b0;
      peek(8'd255, 8'hFF, "full_m255");
      peek(8'd128, 8'h80, "full_m128");
      peek(8'd0, 8'h00, "full_m0");

      // Restart coincident with a valid byte
      base = n_done_seen;
      pulse_start();
      send_byte(8'h03, 0); send_byte(8'h51, 0);
      load_start = 1'b1; stream_if.data = 8'h59; stream_if.valid = 1'b1;
      #1;
      check("restart_ready", 8'(stream_if.ready), 8'h00);
      tick();
      load_start = 1'b0;
      send_byte(8'h01, 0); send_byte(8'h2C, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'hD3, 0);
`endif
      stream_if.valid = 1'b0;
      tick();
      check("restart_done", 8'(n_done_seen - base), 8'd1);
      peek(8'd0, 8'h2C, "restart_m0");
      peek(8'd1, 8'h01, "restart_m1");

      // Start with no following bytes leaves the loader waiting
      pulse_start();
      repeat (20) tick();
      check("stall_hold", 8'(hold), 8'h01);
      check("stall_ready", 8'(stream_if.ready), 8'h01);

      // Randomized loads with restarts, gaps, bad checksums and a mid-load reset
      rnd_rd = 1'b1;
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(1, 24);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 5) == 0) begin
            pulse_start();
            send_byte(8'(n + 3), 2);
            send_byte(8'($urandom_range(0, 255)), 2);
         end
         if (it == 15) begin
            pulse_start();
            send_byte(8'd10, 0);
            send_byte(8'h77, 0);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
         end
         do_load(8'(n), q, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
         junk($urandom_range(1, 4));
      end
      rnd_rd = 1'b0;
      for (int a = 0; a < 256; a++) peek(8'(a), m_mem[a], "final_sweep");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-stream loader. It replaces the fixed instruction ROM in the single-cycle CPU with a 2^ADDR_W x 8 register array. The array is filled at run time from an external byte source (UART receiver or testbench) over a valid/ready handshake. The CPU-side read port keeps the same combinational Instruction/Read_Address behaviour, and Cpu_Hold stalls the PC while a load is in progress.

## Interface
- ADDR_W, 8, address width; memory depth is 2^ADDR_W bytes.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- Load_Start  in  1  single-cycle pulse that begins (or restarts) a load.
- In_Byte  in  8  stream data.
- In_Valid  in  1  In_Byte is valid.
- In_Ready  out  1  loader accepts In_Byte this cycle.
- Read_Address  in  ADDR_W  CPU fetch address.
- Instruction  out  8  combinational read, equal to mem[Read_Address].
- Cpu_Hold  out  1  stalls the CPU PC/register writes.
- Load_Done  out  1  one-cycle pulse on successful completion.
- Load_Error  out  1  sticky checksum failure; constant 0 when checksum support is compiled out.

## Operation
- States: IDLE, LEN, LOAD, CHK, ERR. CHK and ERR exist only when IMEM_LOADER_CHECKSUM_EN is defined.
- A transfer occurs on a rising edge where In_Valid and In_Ready are both high.
- In_Ready = (state is LEN, LOAD or CHK) and not Load_Start. Data offered while In_Ready is low is not consumed.
- Load_Start, from any state:
  - next state is LEN;
  - write pointer = 0;
  - checksum accumulator = 0;
  - Load_Error cleared.
- LEN: the first transfer is the length N.
  - N = 0 means 2^ADDR_W bytes; otherwise N bytes. N is zero-extended or truncated to ADDR_W+1 bits.
  - Next state is LOAD.
- LOAD: each transfer writes mem[ptr] = In_Byte, then ptr increments.
  - After the Nth byte, the next state is CHK if checksum support is compiled in, otherwise IDLE with Load_Done pulsed.
- Addresses at or above N keep their previous contents.
- Read port: fully combinational. A write to address A becomes visible on Instruction at A in the cycle after the accepting edge.
- Cpu_Hold = 1 in LEN, LOAD, CHK and ERR; 0 in IDLE.

## Timing
- Reset values:
  - all memory bytes = 8'h00 (decodes as add $s0,$s0,$s0, harmless);
  - state = IDLE;
  - In_Ready = 0, Cpu_Hold = 0, Load_Done = 0, Load_Error = 0;
  - ptr = 0.
- Reset asserted mid-load aborts the load and clears memory. Reset has priority over Load_Start.
- Cpu_Hold rises in the cycle after the Load_Start edge. In_Ready rises in that same cycle.
- Load_Done is registered. It is high for exactly the one cycle after the final accepted byte (the last payload byte, or the checksum byte). Cpu_Hold falls in that same cycle.
- Throughput is one byte per cycle when In_Valid is held high. Gaps of any length are allowed.
- Load_Start coincident with In_Valid: no transfer (In_Ready is forced low). The restart takes effect.
- ptr wraps modulo 2^ADDR_W. With N = 0 the final write lands at address 2^ADDR_W-1.
- Load_Start in IDLE with no following bytes: the loader stays in LEN with Cpu_Hold high indefinitely.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - An 8-bit modular sum covers the length byte, all payload bytes and one trailing checksum byte accepted in CHK.
  - Sum == 8'h00: go to IDLE and pulse Load_Done.
  - Otherwise: go to ERR with Load_Error = 1 and Cpu_Hold = 1 until the next Load_Start or Reset. In_Ready is low in ERR.
  - Memory keeps the written payload in either case.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - No CHK or ERR states and no accumulator.
  - Load_Error is tied to 0.
  - The load completes after the Nth payload byte.

## Test plan
- Reset, then sweep Read_Address 0..255 -> Instruction = 00 everywhere; Cpu_Hold = 0, In_Ready = 0, Load_Done = 0.
- Checksum disabled. Load_Start, then stream 03, 51, 59, 1B with In_Valid held high -> Load_Done pulses one cycle after 1B is accepted, Cpu_Hold falls with it, Instruction at addresses 0/1/2/3 = 51/59/1B/00.
- Same stream with In_Valid toggled every other cycle -> identical memory contents; each byte is consumed exactly once; Load_Done is delayed accordingly.
- N = 00 followed by 256 bytes i = 0..255 -> mem[i] = i, address 255 holds FF, then Load_Done. A 257th byte is not accepted (In_Ready = 0).
- Checksum enabled. Stream 02, 51, 59, 54 -> Load_Done pulses, Load_Error = 0. Repeat with 55 as the last byte -> Load_Error = 1, Cpu_Hold stays 1, no Load_Done; a following Load_Start clears Load_Error.
- Load_Start, 03, 51, then Load_Start pulsed together with In_Valid on 59 -> 59 not accepted; the next bytes 01, 2C give mem[0] = 2C and Load_Done.
